// File: rtl/alu_core.sv
// alu_core: 16-bit saturating execute-stage ALU with registered {Z,V,N} condition flags.
// Define ALU_ROR_EN to build the rotate-right datapath for opcode 0110.
module alu_core (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic [3:0]  imm,
   input  logic [3:0]  opcode,
   output logic [15:0] Sum,
   output logic [2:0]  flags
);

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_RED    = 4'b0010;
   localparam logic [3:0] OP_XOR    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;

   logic [16:0] addWide;
   logic [16:0] subWide;
   logic        addSat;
   logic        subSat;
   logic [15:0] addResult;
   logic [15:0] subResult;
   logic [6:0]  redAcc;
   logic [15:0] redResult;
   logic [15:0] packResult;
   logic [15:0] sllResult;
   logic [15:0] sraResult;
   logic [2:0]  flags_d;
   logic [2:0]  flags_q;

   // Signed nibble add clamped to [-8, 7]; lanes never share a carry.
   function automatic logic [3:0] sat4(input logic [3:0] x, input logic [3:0] y);
      logic [4:0] s;
      s = {x[3], x} + {y[3], y};
      if (s[4] != s[3]) begin
         return s[4] ? 4'h8 : 4'h7;
      end
      return s[3:0];
   endfunction

   // A 17-bit result whose top two bits disagree has left the 16-bit signed range.
   assign addWide   = {A[15], A} + {B[15], B};
   assign subWide   = {A[15], A} - {B[15], B};
   assign addSat    = addWide[16] ^ addWide[15];
   assign subSat    = subWide[16] ^ subWide[15];
   assign addResult = addSat ? (addWide[16] ? 16'h8000 : 16'h7FFF) : addWide[15:0];
   assign subResult = subSat ? (subWide[16] ? 16'h8000 : 16'h7FFF) : subWide[15:0];

   assign sllResult = A << imm;
   assign sraResult = $signed(A) >>> imm;

`ifdef ALU_ROR_EN
   logic [15:0] rorResult;

   // A left shift by 16 contributes nothing, so imm=0 passes A through.
   assign rorResult = (A >> imm) | (A << (5'd16 - {1'b0, imm}));
`endif

   always_comb begin
      redAcc = 7'd0;
      for (int k = 0; k < 4; k++) begin
         redAcc = redAcc + {3'b000, A[4*k +: 4]} + {3'b000, B[4*k +: 4]};
      end
   end

   assign redResult = {9'd0, redAcc};

   always_comb begin
      packResult = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         packResult[4*k +: 4] = sat4(A[4*k +: 4], B[4*k +: 4]);
      end
   end

   // Result mux and next-flag selection; flags hold unless the opcode owns them.
   always_comb begin
      Sum     = 16'h0000;
      flags_d = flags_q;
      case (opcode)
         OP_ADD: begin
            Sum     = addResult;
            flags_d = {addResult == 16'h0000, addSat, addResult[15]};
         end
         OP_SUB: begin
            Sum     = subResult;
            flags_d = {subResult == 16'h0000, subSat, subResult[15]};
         end
         OP_RED: begin
            Sum = redResult;
         end
         OP_XOR: begin
            Sum        = A ^ B;
            flags_d[2] = ((A ^ B) == 16'h0000);
         end
         OP_SLL: begin
            Sum        = sllResult;
            flags_d[2] = (sllResult == 16'h0000);
         end
         OP_SRA: begin
            Sum        = sraResult;
            flags_d[2] = (sraResult == 16'h0000);
         end
         OP_ROR: begin
`ifdef ALU_ROR_EN
            Sum        = rorResult;
            flags_d[2] = (rorResult == 16'h0000);
`else
            Sum = 16'h0000;
`endif
         end
         OP_PADDSB: begin
            Sum = packResult;
         end
         default: begin
            Sum = A + B;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= 3'b000;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags = flags_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed plus randomized checks of alu_core against an integer reference model.
// Honours ALU_ROR_EN so the expected opcode-0110 behaviour matches the build.
module tb_alu_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] A = 16'h0000;
   logic [15:0] B = 16'h0000;
   logic [3:0]  imm = 4'h0;
   logic [3:0]  opcode = 4'h0;
   logic [15:0] Sum;
   logic [2:0]  flags;

   int          checkCount = 0;
   int          miscompares = 0;
   logic [2:0]  expFlags = 3'b000;

   alu_core dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .B      (B),
      .imm    (imm),
      .opcode (opcode),
      .Sum    (Sum),
      .flags  (flags)
   );

   always #5 clk = ~clk;

   // Reference result computed with plain integer arithmetic and clamping.
   function automatic logic [15:0] modelSum(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] sh, input logic [3:0] op,
                                            output bit sat);
      int r;
      int x;
      int y;
      sat = 1'b0;
      r = 0;
      if (op == 4'd0 || op == 4'd1) begin
         r = (op == 4'd0) ? int'($signed(a)) + int'($signed(b))
                          : int'($signed(a)) - int'($signed(b));
         if (r > 32767) begin
            r = 32767;
            sat = 1'b1;
         end else if (r < -32768) begin
            r = -32768;
            sat = 1'b1;
         end
      end else if (op == 4'd2) begin
         for (int i = 0; i < 4; i++) begin
            r = r + ((int'(a) >> (4 * i)) & 15) + ((int'(b) >> (4 * i)) & 15);
         end
      end else if (op == 4'd3) begin
         r = int'(a ^ b);
      end else if (op == 4'd4) begin
         r = int'(a) << sh;
      end else if (op == 4'd5) begin
         r = int'($signed(a));
         r = r >>> sh;
      end else if (op == 4'd6) begin
`ifdef ALU_ROR_EN
         r = (int'(a) >> sh) | (int'(a) << (16 - int'(sh)));
`else
         r = 0;
`endif
      end else if (op == 4'd7) begin
         for (int i = 0; i < 4; i++) begin
            x = (int'(a) >> (4 * i)) & 15;
            y = (int'(b) >> (4 * i)) & 15;
            if (x > 7) x = x - 16;
            if (y > 7) y = y - 16;
            x = x + y;
            if (x > 7) x = 7;
            if (x < -8) x = -8;
            r = r | ((x & 15) << (4 * i));
         end
      end else begin
         r = int'(a) + int'(b);
      end
      return 16'(r);
   endfunction

   // Which flags each opcode family owns; everything else holds.
   function automatic logic [2:0] modelFlags(input logic [2:0] cur, input logic [15:0] s,
                                             input bit sat, input logic [3:0] op);
      logic [2:0] nf;
      nf = cur;
      if (op == 4'd0 || op == 4'd1) begin
         nf = {s == 16'h0000, sat, s[15]};
      end else if (op == 4'd3 || op == 4'd4 || op == 4'd5) begin
         nf[2] = (s == 16'h0000);
      end else if (op == 4'd6) begin
`ifdef ALU_ROR_EN
         nf[2] = (s == 16'h0000);
`endif
      end
      return nf;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %h expected %h (A=%h B=%h imm=%0d op=%0d)",
                  tag, observed, expected, A, B, imm, opcode);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] sh, input logic [3:0] op);
      logic [15:0] expSum;
      logic [2:0]  nextFlags;
      bit          sat;
      @(negedge clk);
      A = a;
      B = b;
      imm = sh;
      opcode = op;
      #1;
      expSum = modelSum(a, b, sh, op, sat);
      checkOutput("sum", Sum, expSum);
      nextFlags = modelFlags(expFlags, expSum, sat, op);
      @(posedge clk);
      #1;
      expFlags = nextFlags;
      checkOutput("flags", {13'd0, flags}, {13'd0, expFlags});
   endtask

   function automatic logic [15:0] pickOperand();
      logic [15:0] pool [6];
      pool[0] = 16'h0000;
      pool[1] = 16'h0001;
      pool[2] = 16'h7FFF;
      pool[3] = 16'h8000;
      pool[4] = 16'hFFFF;
      pool[5] = 16'h7FFE;
      if ($urandom_range(0, 3) == 0) begin
         return pool[$urandom_range(0, 5)];
      end
      return 16'($urandom);
   endfunction

   initial begin
      // Reset held across edges keeps flags clear.
      #12;
      checkOutput("resetFlags", {13'd0, flags}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(16'h7FFF, 16'h0001, 4'd0, 4'd0);
      applyStimulus(16'h1234, 16'h1111, 4'd0, 4'd0);
      applyStimulus(16'h8000, 16'h0001, 4'd0, 4'd1);
      applyStimulus(16'h0005, 16'h0005, 4'd0, 4'd1);
      applyStimulus(16'h7FFE, 16'h0001, 4'd0, 4'd0);
      applyStimulus(16'h8001, 16'h0001, 4'd0, 4'd1);
      applyStimulus(16'hFFFF, 16'hFFFF, 4'd0, 4'd2);
      applyStimulus(16'h7788, 16'h1188, 4'd0, 4'd7);
      applyStimulus(16'h1234, 16'h1111, 4'd0, 4'd7);
      applyStimulus(16'h0001, 16'h0000, 4'd15, 4'd4);
      applyStimulus(16'h8000, 16'h0000, 4'd4, 4'd5);
      applyStimulus(16'h8000, 16'h0000, 4'd15, 4'd5);
      applyStimulus(16'h7ABC, 16'h0000, 4'd15, 4'd5);
      applyStimulus(16'hA5C3, 16'h0000, 4'd0, 4'd4);
      applyStimulus(16'hA5C3, 16'h0000, 4'd0, 4'd5);
      applyStimulus(16'h0001, 16'h0000, 4'd1, 4'd6);
      applyStimulus(16'hA5C3, 16'h0000, 4'd0, 4'd6);
      applyStimulus(16'hFFF0, 16'h0020, 4'd0, 4'd9);

      // Build flags = 111, then reset between edges.
      applyStimulus(16'h8000, 16'h0001, 4'd0, 4'd1);
      applyStimulus(16'hAAAA, 16'hAAAA, 4'd0, 4'd3);
      checkOutput("flagsAllSet", {13'd0, flags}, 16'h0007);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rstAsync", {13'd0, flags}, 16'h0000);
      expFlags = 3'b000;
      A = 16'h7FFF;
      B = 16'h0001;
      opcode = 4'd0;
      #1;
      checkOutput("sumDuringRst", Sum, 16'h7FFF);
      @(posedge clk);
      #1;
      checkOutput("rstHold", {13'd0, flags}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(16'h7FFF, 16'h0001, 4'd0, 4'd0);

      for (int n = 0; n < 400; n++) begin
         applyStimulus(pickOperand(), pickOperand(), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", checkCount, miscompares);
      $finish;
   end

endmodule
